fifo_rd_ctrl: RTL and testbench



---
 rtl/fifo_rd_ctrl.sv | 111 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Purpose: read-side controller of an async FIFO; syncs the Gray write pointer, drives the memory read address, presents words through a one-entry output register.
// Latency: a stable wptr change reaches rempty on the 3rd rclk edge and rd_valid on the 4th; after that, one word per rclk.
// Backpressure: rd_valid && !rd_ready freezes rd_data, rd_valid and the read pointer; the next pop may happen on the same edge as a consume.
//
// Ports:
//   rclk, rrst        read clock, synchronous active-high reset
//   wptr              Gray write pointer from the write domain (async to rclk)
//   rdata / raddr     combinational memory read data / read address (rbin[ADDRSIZE-1:0])
//   rptr              registered Gray read pointer for the write domain
//   rempty            registered empty flag
//   rd_valid/rd_ready/rd_data  valid/ready output register
//   rd_level          words left in memory, excluding the output register
module fifo_rd_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATASIZE-1:0] rd_data,
  output logic [ADDRSIZE:0]   rd_level
);

  localparam int PW = ADDRSIZE + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]       rq1_wptr_q, rq1_wptr_d;
  logic [PW-1:0]       rq2_wptr_q, rq2_wptr_d;
  logic [PW-1:0]       rbin_q, rbin_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic                rempty_q, rempty_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATASIZE-1:0] rd_data_q, rd_data_d;
  logic [PW-1:0]       rd_level_q, rd_level_d;

  logic                pop;
  logic [PW-1:0]       rbin_next;
  logic [PW-1:0]       rgray_next;

  always_comb begin
    rq1_wptr_d = wptr;
    rq2_wptr_d = rq1_wptr_q;

    // Pop whenever memory holds a word and the output register is free
    // or being drained on this same edge.
    pop        = !rempty_q && (!rd_valid_q || rd_ready);
    rbin_next  = rbin_q + {{ADDRSIZE{1'b0}}, pop};
    rgray_next = (rbin_next >> 1) ^ rbin_next;

    rbin_d     = rbin_next;
    rptr_d     = rgray_next;
    // Comparing against the post-pop pointer makes rempty rise on the
    // edge that takes the last visible word, with no bubble.
    rempty_d   = (rgray_next == rq2_wptr_q);
    // Uses the synchronized pointer, so the level can lag but never overstate.
    rd_level_d = gray2bin(rq2_wptr_q) - rbin_next;

    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (pop) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rdata;
    end else if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq1_wptr_q <= '0;
      rq2_wptr_q <= '0;
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_level_q <= '0;
    end else begin
      rq1_wptr_q <= rq1_wptr_d;
      rq2_wptr_q <= rq2_wptr_d;
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_level_q <= rd_level_d;
    end
  end

  assign raddr    = rbin_q[ADDRSIZE-1:0];
  assign rptr     = rptr_q;
  assign rempty   = rempty_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_level = rd_level_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Purpose: self-checking bench for fifo_rd_ctrl with a behavioural memory and write pointer.
// Latency: checks sync/empty/valid timing edge by edge after each wptr step.
// Backpressure: random and directed rd_ready; a monitor scores every accepted word.
module tb_fifo_rd_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic [AW:0]   wptr = '0;
  logic [DW-1:0] rdata;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW:0]   rd_level;

  logic [DW-1:0] mem [DEPTH];
  assign rdata = mem[raddr];

  fifo_rd_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .wptr     (wptr),
    .rdata    (rdata),
    .raddr    (raddr),
    .rptr     (rptr),
    .rempty   (rempty),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_level (rd_level)
  );

  always #5 rclk = ~rclk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q [$];
  int            wbin = 0;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = (AW+1)'(b);
    return (v >> 1) ^ v;
  endfunction

  function automatic int g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    mem[wbin % DEPTH] = d;
    exp_q.push_back(d);
    wbin++;
    wptr = gray(wbin);
  endtask

  task automatic do_reset();
    rrst     = 1'b1;
    rd_ready = 1'b0;
    wptr     = '0;
    wbin     = 0;
    exp_q.delete();
    step(2);
    rrst = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < lim) begin
      step(1);
      c++;
    end
    check("drain complete", exp_q.size(), 0);
  endtask

  // Monitor: scores each accepted word against the scoreboard and checks
  // that rptr only ever moves by a single bit.
  logic [AW:0] prev_rptr = '0;
  bit          prev_ok   = 1'b0;

  always @(negedge rclk) begin
    if (rrst) begin
      prev_ok = 1'b0;
    end else begin
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_data unexpected word: got %0h expected none", rd_data);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("rd_data order", rd_data, e);
        end
      end
      if (prev_ok && rptr !== prev_rptr)
        check("rptr one-bit step", $countones(rptr ^ prev_rptr), 1);
      prev_rptr = rptr;
      prev_ok   = 1'b1;
    end
  end

  initial begin
    logic [DW-1:0] bp [4];
    int written;
    int cyc;
    bp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // Reset values
    rrst = 1'b1;
    wptr = '0;
    step(2);
    check("reset rempty", rempty, 1);
    check("reset rd_valid", rd_valid, 0);
    check("reset rptr", rptr, 0);
    check("reset raddr", raddr, 0);
    check("reset rd_level", rd_level, 0);
    check("reset rd_data", rd_data, 0);
    wptr = gray(3);
    step(3);
    check("held reset rempty", rempty, 1);
    check("held reset rd_valid", rd_valid, 0);
    check("held reset rd_level", rd_level, 0);
    check("held reset rptr", rptr, 0);
    wptr = '0;
    step(1);
    rrst = 1'b0;

    // Single word, edge-by-edge latency
    rd_ready = 1'b1;
    push_word(8'hA5);
    step(2);
    check("single rempty before edge3", rempty, 1);
    step(1);
    check("single rempty at edge3", rempty, 0);
    check("single rd_valid at edge3", rd_valid, 0);
    step(1);
    check("single rd_valid at edge4", rd_valid, 1);
    check("single rd_data at edge4", rd_data, 8'hA5);
    check("single raddr at edge4", raddr, 1);
    check("single rptr at edge4", rptr, 1);
    check("single rempty at edge4", rempty, 1);
    step(1);
    check("single rd_valid at edge5", rd_valid, 0);

    // Backpressure
    do_reset();
    for (int i = 0; i < 4; i++) push_word(bp[i]);
    step(6);
    check("stall rd_valid", rd_valid, 1);
    check("stall rd_data", rd_data, 8'h11);
    check("stall rd_level", rd_level, 3);
    check("stall rptr", rptr, gray(1));
    check("stall rempty", rempty, 0);
    step(3);
    check("stall hold rd_data", rd_data, 8'h11);
    check("stall hold rd_level", rd_level, 3);
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("burst rd_valid", rd_valid, 1);
      check("burst rd_data", rd_data, bp[k]);
      step(1);
    end
    check("burst end rd_valid", rd_valid, 0);
    check("burst end rempty", rempty, 1);
    check("burst end scoreboard", exp_q.size(), 0);

    // Full depth
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_word(8'(8'h80 + i));
    step(6);
    check("full rd_level", rd_level, 15);
    check("full rd_valid", rd_valid, 1);
    check("full rd_data", rd_data, 8'h80);
    check("full rempty", rempty, 0);
    rd_ready = 1'b1;
    wait_drain(100);
    step(2);
    check("full drained rempty", rempty, 1);
    check("full drained rd_valid", rd_valid, 0);
    check("full drained rd_level", rd_level, 0);
    check("full drained rptr", rptr, gray(16));
    check("full drained raddr", raddr, 0);

    // Wrap-around stream with random consumer
    do_reset();
    written = 0;
    cyc = 0;
    while ((written < 40 || exp_q.size() != 0) && cyc < 3000) begin
      rd_ready = 1'($urandom_range(0, 1));
      if (written < 40 && ((wbin - g2b(rptr)) & 31) < DEPTH) begin
        push_word(8'(written * 7 + 3));
        written++;
      end
      step(1);
      cyc++;
    end
    rd_ready = 1'b1;
    step(3);
    check("wrap stream complete", (written == 40 && exp_q.size() == 0), 1);
    check("wrap raddr", raddr, 8);
    check("wrap rptr", rptr, gray(8));
    check("wrap rempty", rempty, 1);
    check("wrap rd_valid", rd_valid, 0);
    check("wrap rd_level", rd_level, 0);

    // Reset mid-stream
    do_reset();
    for (int i = 0; i < 6; i++) push_word(8'(8'hC0 + i));
    step(6);
    check("pre-reset rd_valid", rd_valid, 1);
    check("pre-reset rd_level", rd_level, 5);
    rrst = 1'b1;
    wptr = '0;
    wbin = 0;
    exp_q.delete();
    step(1);
    check("mid reset rd_valid", rd_valid, 0);
    check("mid reset rempty", rempty, 1);
    check("mid reset rptr", rptr, 0);
    check("mid reset rd_level", rd_level, 0);
    check("mid reset raddr", raddr, 0);
    rrst = 1'b0;
    step(4);
    check("post reset rd_valid", rd_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
